// File: rtl/lfsr16_gen.sv
// lfsr16_gen
//   Free-running, seedable Fibonacci LFSR. One new WIDTH-bit word per clock.
//   The default taps are maximal-length, giving a period of 2^16-1.
//   The output sequence must match a software golden model bit for bit:
//   shift left, feedback into the LSB, MSB discarded.
//
// Ports
//   clk       in   1      rising-edge clock
//   resetn    in   1      asynchronous active-low reset; loads seed
//   seed      in   WIDTH  initial state, used only while resetn is low
//   lfsr_out  out  WIDTH  current state, straight from the state register
//
// Parameters
//   WIDTH     state/output width
//   TAPS      feedback mask; bit k set means state[k] feeds the XOR
//   STEPS     shifts applied per clock (1..WIDTH), unrolled combinationally
//   ZERO_SUB  loaded in place of an all-zero seed (zero is the lock-up state)
module lfsr16_gen #(
  parameter int              WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
  parameter int              STEPS    = 1,
  parameter logic [WIDTH-1:0] ZERO_SUB = 16'h0001
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] lfsr_out
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] next_state;
  logic [WIDTH-1:0] seed_eff;

  // The all-zero state would lock the register, so it is never loaded.
  assign seed_eff = (seed == '0) ? ZERO_SUB : seed;

  // Apply the one-step rule STEPS times within the same cycle.
  always_comb begin
    next_state = state;
    for (int i = 0; i < STEPS; i++) begin
      next_state = {next_state[WIDTH-2:0], ^(next_state & TAPS)};
    end
  end

  // The reset branch also runs on each clock edge while resetn is held low,
  // so a seed change during reset reaches the register without a release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= seed_eff;
    end else begin
      state <= next_state;
    end
  end

  assign lfsr_out = state;

endmodule

// File: tb/tb_lfsr16_gen.sv
module tb_lfsr16_gen;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] seed = 16'd10;
  logic [15:0] lfsr_out;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  lfsr16_gen dut (
    .clk      (clk),
    .resetn   (resetn),
    .seed     (seed),
    .lfsr_out (lfsr_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the output bit stream obeys the recurrence
  // b[n] = b[n-16] ^ b[n-14] ^ b[n-13] ^ b[n-11], and the output word is the
  // most recent 16 bits, newest bit in the LSB.
  bit hist[$];

  function automatic logic [15:0] model_word();
    logic [15:0] w;
    w = '0;
    for (int k = 0; k < 16; k++) w[k] = hist[hist.size() - 1 - k];
    return w;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      logic [15:0] s;
      s = (seed == 16'h0000) ? 16'h0001 : seed;
      hist.delete();
      for (int k = 15; k >= 0; k--) hist.push_back(s[k]);
    end else if (hist.size() == 16) begin
      hist.push_back(hist[0] ^ hist[2] ^ hist[3] ^ hist[5]);
      void'(hist.pop_front());
    end
  end

  // Per-cycle comparison against the model, well clear of the clock edge.
  always @(posedge clk) begin
    #4;
    if (chk_en && hist.size() == 16) begin
      chk("model", lfsr_out, model_word());
      checks++;
      if (lfsr_out == 16'h0000) begin
        failures++;
        $display("FAIL nonzero: got %h expected any nonzero value at %0t", lfsr_out, $time);
      end
    end
  end

  logic [15:0] exp8 [8] = '{16'h0014, 16'h0028, 16'h0050, 16'h00A0,
                            16'h0140, 16'h0280, 16'h0500, 16'h0A01};
  logic [15:0] rec [100];
  bit          seen [65536];
  int          bad_repeat;
  logic [15:0] v;

  initial begin
    // Seed 10: reset value, then the hand-computed first eight words.
    #12;
    chk("reset_seed10", lfsr_out, 16'h000A);
    @(negedge clk);
    resetn = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #3;
      chk($sformatf("seed10_step%0d", i + 1), lfsr_out, exp8[i]);
    end
    repeat (248) @(posedge clk);

    // seed is ignored while running.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      seed = 16'($urandom);
    end

    // Zero seed is replaced; seed changes during reset propagate.
    @(negedge clk);
    seed = 16'h0000;
    resetn = 1'b0;
    #1 chk("reset_zero_sub", lfsr_out, 16'h0001);
    @(negedge clk);
    seed = 16'h00FF;
    @(posedge clk); #3;
    chk("reset_seed_change", lfsr_out, 16'h00FF);
    @(negedge clk);
    seed = 16'h0000;
    @(posedge clk); #3;
    chk("reset_back_to_zero", lfsr_out, 16'h0001);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #3;
    chk("zero_seed_step1", lfsr_out, 16'h0002);
    @(posedge clk); #3;
    chk("zero_seed_step2", lfsr_out, 16'h0004);
    repeat (200) @(posedge clk);

    // Asynchronous reset mid-sequence, then identical restart.
    @(negedge clk);
    seed = 16'h1234;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #3;
      rec[i] = lfsr_out;
    end
    resetn = 1'b0;
    #1 chk("async_reload", lfsr_out, 16'h1234);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #3;
      chk($sformatf("restart_%0d", i), lfsr_out, rec[i]);
    end

    // Full period from 0xACE1.
    @(negedge clk);
    seed = 16'hACE1;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    seen[16'hACE1] = 1'b1;
    bad_repeat = 0;
    for (int k = 1; k <= 65535; k++) begin
      @(posedge clk); #3;
      v = lfsr_out;
      if (k < 65535) begin
        if (seen[v] || v == 16'h0000) bad_repeat++;
        seen[v] = 1'b1;
      end
    end
    chk("period_return", v, 16'hACE1);
    checks++;
    if (bad_repeat != 0) begin
      failures++;
      $display("FAIL early_repeat: got %0d repeats expected 0", bad_repeat);
    end

    chk_en = 1'b0;
    #20;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
